// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter slice.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 32;
  localparam logic [3:0]  FULL_BE    = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_D,
    BUSY_I
  } arbState_t;

  // Data-grant streak: counts only while a fetch is waiting, saturating at lim.
  function automatic logic [3:0] nextStreak(input logic [3:0] cur,
                                            input logic [3:0] lim,
                                            input logic       fetchWaiting);
    if (!fetchWaiting)
      return '0;
    else if (cur >= lim)
      return lim;
    else
      return cur + 4'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Processor-side (fetch/data) and memory-side handshake bundle of the arbiter.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              IReq;
  logic [ADDR_W-1:0] IAddr;
  logic [DATA_W-1:0] IData;
  logic              IAck;

  logic              DRead;
  logic              DWrite;
  logic [ADDR_W-1:0] DAddr;
  logic [DATA_W-1:0] DWData;
  logic [3:0]        DByteEn;
  logic [DATA_W-1:0] DRData;
  logic              DAck;

  logic              MReq;
  logic              MWe;
  logic [ADDR_W-1:0] MAddr;
  logic [DATA_W-1:0] MWData;
  logic [3:0]        MByteEn;
  logic [DATA_W-1:0] MRData;
  logic              MAck;

  modport master (
    input  IReq, IAddr, DRead, DWrite, DAddr, DWData, DByteEn, MRData, MAck,
    output IData, IAck, DRData, DAck, MReq, MWe, MAddr, MWData, MByteEn
  );

  modport slave (
    output IReq, IAddr, DRead, DWrite, DAddr, DWData, DByteEn, MRData, MAck,
    input  IData, IAck, DRData, DAck, MReq, MWe, MAddr, MWData, MByteEn
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store ports onto one single-port memory; data has
// priority, a streak counter forces a pending fetch after STARVE_MAX data grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          Clock,
  input  logic          nReset,
  mem_arbiter_if.master bus,
  output logic          Stall,
  output logic          ProtErr
);

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);

  arbState_t         state;
  logic [3:0]        streak;
  logic              mReq;
  logic              mWe;
  logic [ADDR_W-1:0] mAddr;
  logic [DATA_W-1:0] mWData;
  logic [3:0]        mByteEn;
  logic [DATA_W-1:0] iData;
  logic [DATA_W-1:0] dRData;
  logic              iAck;
  logic              dAck;

  logic dPend;
  logic iPend;
  logic ackCycle;
  logic dGrant;
  logic iGrant;

  always_comb begin
    dPend    = bus.DRead | bus.DWrite;
    iPend    = bus.IReq;
    ackCycle = iAck | dAck;
    dGrant   = dPend & (~iPend | (streak < STREAK_MAX));
    iGrant   = iPend & ~dGrant;
  end

  assign Stall = (bus.IReq & ~iAck) | ((bus.DRead | bus.DWrite) & ~dAck);

  assign bus.MReq    = mReq;
  assign bus.MWe     = mWe;
  assign bus.MAddr   = mAddr;
  assign bus.MWData  = mWData;
  assign bus.MByteEn = mByteEn;
  assign bus.IData   = iData;
  assign bus.DRData  = dRData;
  assign bus.IAck    = iAck;
  assign bus.DAck    = dAck;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state   <= IDLE;
      streak  <= '0;
      mReq    <= 1'b0;
      mWe     <= 1'b0;
      mAddr   <= '0;
      mWData  <= '0;
      mByteEn <= '0;
      iData   <= '0;
      dRData  <= '0;
      iAck    <= 1'b0;
      dAck    <= 1'b0;
      ProtErr <= 1'b0;
    end else begin
      iAck <= 1'b0;
      dAck <= 1'b0;
      if (bus.DRead & bus.DWrite)
        ProtErr <= 1'b1;

      unique case (state)
        IDLE: begin
          if (bus.MAck)
            ProtErr <= 1'b1;
          // No issue in an Ack cycle: the finishing requester still holds its
          // request, and skipping the cycle for both keeps the streak meaningful.
          if (!ackCycle) begin
            if (dGrant) begin
              state   <= BUSY_D;
              mReq    <= 1'b1;
              mAddr   <= bus.DAddr;
              mWe     <= bus.DWrite;
              mWData  <= bus.DWrite ? bus.DWData : '0;
              mByteEn <= bus.DWrite ? bus.DByteEn : FULL_BE;
              streak  <= nextStreak(streak, STREAK_MAX, iPend);
            end else if (iGrant) begin
              state   <= BUSY_I;
              mReq    <= 1'b1;
              mAddr   <= bus.IAddr;
              mWe     <= 1'b0;
              mWData  <= '0;
              mByteEn <= FULL_BE;
              streak  <= '0;
            end
          end
        end

        BUSY_D: begin
          if (bus.MAck) begin
            state <= IDLE;
            mReq  <= 1'b0;
            dAck  <= 1'b1;
            if (!mWe)
              dRData <= bus.MRData;
          end
        end

        BUSY_I: begin
          if (bus.MAck) begin
            state <= IDLE;
            mReq  <= 1'b0;
            iAck  <= 1'b1;
            iData <= bus.MRData;
          end
        end

        default: begin
          state <= IDLE;
          mReq  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single-transaction vector table plus arbitration,
// starvation, protocol-error and mid-transaction reset sequences.
module tb_mem_arbiter;

  logic Clock;
  logic nReset;
  logic Stall;
  logic ProtErr;

  int checks = 0;
  int errors = 0;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_MAX(4)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus),
    .Stall  (Stall),
    .ProtErr(ProtErr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Memory model: MAck after memK cycles of MReq (memK = 0 acks in the MReq cycle).
  logic [31:0] memData;
  int          memK;
  int          memCnt;
  logic        spurAck;

  assign bus.MAck   = (bus.MReq & (memCnt == memK)) | spurAck;
  assign bus.MRData = memData;

  always @(posedge Clock or negedge nReset) begin
    if (!nReset)
      memCnt <= 0;
    else if (bus.MReq && !bus.MAck)
      memCnt <= memCnt + 1;
    else
      memCnt <= 0;
  end

  typedef struct {
    logic        isData;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] mem;
    int          k;
    logic        expWe;
    logic [3:0]  expBe;
    logic [31:0] expRData;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic clearInputs;
    bus.IReq    = 1'b0;
    bus.IAddr   = '0;
    bus.DRead   = 1'b0;
    bus.DWrite  = 1'b0;
    bus.DAddr   = '0;
    bus.DWData  = '0;
    bus.DByteEn = '0;
    memData     = '0;
    memK        = 0;
    spurAck     = 1'b0;
  endtask

  task automatic doReset;
    clearInputs();
    nReset = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    nReset = 1'b1;
    tick();
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_MReq"},    bus.MReq,    0);
    chk({tag, "_MWe"},     bus.MWe,     0);
    chk({tag, "_MAddr"},   bus.MAddr,   0);
    chk({tag, "_MWData"},  bus.MWData,  0);
    chk({tag, "_MByteEn"}, bus.MByteEn, 0);
    chk({tag, "_IData"},   bus.IData,   0);
    chk({tag, "_DRData"},  bus.DRData,  0);
    chk({tag, "_IAck"},    bus.IAck,    0);
    chk({tag, "_DAck"},    bus.DAck,    0);
    chk({tag, "_ProtErr"}, ProtErr,     0);
    chk({tag, "_Stall"},   Stall,       0);
  endtask

  // Waits (bounded) for a signal selected by sel: 0 = DAck, 1 = IAck, 2 = MReq.
  task automatic waitFor(input int sel, input string name);
    int   n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      tick();
      n++;
      seen = (sel == 0) ? bus.DAck : (sel == 1) ? bus.IAck : bus.MReq;
    end
    chk({name, "_seen"}, seen, 1);
  endtask

  task automatic applyVec(input vec_t v, input int idx);
    int    cyc;
    logic  gotAck;
    string tag;
    tag = $sformatf("vec%0d", idx);
    bus.IReq    = ~v.isData;
    bus.IAddr   = v.addr;
    bus.DRead   = v.rd;
    bus.DWrite  = v.wr;
    bus.DAddr   = v.addr;
    bus.DWData  = v.wdata;
    bus.DByteEn = v.be;
    memData     = v.mem;
    memK        = v.k;
    #1;
    chk({tag, "_stall_c0"}, Stall, 1);
    chk({tag, "_mreq_c0"}, bus.MReq, 0);
    cyc    = 0;
    gotAck = 1'b0;
    while (!gotAck && cyc < 20) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        chk({tag, "_MReq"},    bus.MReq,    1);
        chk({tag, "_MAddr"},   bus.MAddr,   v.addr);
        chk({tag, "_MWe"},     bus.MWe,     v.expWe);
        chk({tag, "_MByteEn"}, bus.MByteEn, v.expBe);
        chk({tag, "_stall_c1"}, Stall, 1);
        if (v.wr)
          chk({tag, "_MWData"}, bus.MWData, v.wdata);
      end
      gotAck = v.isData ? bus.DAck : bus.IAck;
    end
    chk({tag, "_latency"}, cyc, v.k + 2);
    chk({tag, "_rdata"}, v.isData ? bus.DRData : bus.IData, v.expRData);
    chk({tag, "_stall_ack"}, Stall, 0);
    chk({tag, "_mreq_ack"}, bus.MReq, 0);
    chk({tag, "_protErr"}, ProtErr, 0);
    bus.IReq   = 1'b0;
    bus.DRead  = 1'b0;
    bus.DWrite = 1'b0;
    tick();
    chk({tag, "_ack_drop"}, bus.IAck | bus.DAck, 0);
    chk({tag, "_mreq_after"}, bus.MReq, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // isData rd wr addr wdata be mem k | expWe expBe expRData
    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0010, 32'h0,        4'h0, 32'hDEADBEEF, 0, 1'b0, 4'hF, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 16'h0100, 32'h0,        4'h0, 32'hCAFEF00D, 1, 1'b0, 4'hF, 32'hCAFEF00D};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 16'h0040, 32'h12345678, 4'h3, 32'hAAAAAAAA, 3, 1'b1, 4'h3, 32'hCAFEF00D};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h00FC, 32'h0,        4'h6, 32'h01234567, 2, 1'b0, 4'hF, 32'h01234567};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 16'hFFFC, 32'h0,        4'h0, 32'h89ABCDEF, 4, 1'b0, 4'hF, 32'h89ABCDEF};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 32'hFFFFFFFF, 4'hF, 32'h55555555, 0, 1'b1, 4'hF, 32'h01234567};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 16'h0000, 32'h0,        4'h0, 32'h77777777, 1, 1'b1, 4'h0, 32'h01234567};

    doReset();
    chkAllZero("reset");

    foreach (vecs[i]) applyVec(vecs[i], i);

    // Simultaneous fetch and load: data first, then the fetch.
    doReset();
    bus.IReq  = 1'b1;
    bus.IAddr = 16'h0200;
    bus.DRead = 1'b1;
    bus.DAddr = 16'h0100;
    memData   = 32'h11111111;
    memK      = 0;
    tick();
    chk("simul_first_MAddr", bus.MAddr, 16'h0100);
    chk("simul_first_MWe", bus.MWe, 0);
    waitFor(0, "simul_dack");
    chk("simul_DRData", bus.DRData, 32'h11111111);
    chk("simul_no_iack", bus.IAck, 0);
    bus.DRead = 1'b0;
    memData   = 32'h22222222;
    waitFor(2, "simul_igrant");
    chk("simul_second_MAddr", bus.MAddr, 16'h0200);
    waitFor(1, "simul_iack");
    chk("simul_IData", bus.IData, 32'h22222222);
    bus.IReq = 1'b0;
    tick();

    // Starvation: both held continuously -> D x4 then I, twice over.
    doReset();
    bus.IReq  = 1'b1;
    bus.IAddr = 16'h0300;
    bus.DRead = 1'b1;
    bus.DAddr = 16'h0400;
    memData   = 32'h33333333;
    memK      = 0;
    begin
      logic prevReq;
      prevReq = 1'b0;
      for (int r = 0; r < 2; r++) begin
        int   dCount;
        logic iSeen;
        dCount = 0;
        iSeen  = 1'b0;
        for (int c = 0; c < 40 && !iSeen; c++) begin
          tick();
          if (bus.MReq && !prevReq) begin
            if (bus.MAddr == 16'h0400)
              dCount++;
            else if (bus.MAddr == 16'h0300)
              iSeen = 1'b1;
          end
          prevReq = bus.MReq;
        end
        chk($sformatf("starve_dgrants_r%0d", r), dCount, 4);
        chk($sformatf("starve_igrant_r%0d", r), iSeen, 1);
      end
    end
    clearInputs();
    repeat (4) tick();

    // Read and write together: treated as a write, sticky ProtErr.
    doReset();
    bus.DRead   = 1'b1;
    bus.DWrite  = 1'b1;
    bus.DAddr   = 16'h0080;
    bus.DWData  = 32'h5A5A5A5A;
    bus.DByteEn = 4'hC;
    memData     = 32'h99999999;
    memK        = 0;
    tick();
    chk("both_MWe", bus.MWe, 1);
    chk("both_MByteEn", bus.MByteEn, 4'hC);
    chk("both_MWData", bus.MWData, 32'h5A5A5A5A);
    chk("both_ProtErr", ProtErr, 1);
    waitFor(0, "both_dack");
    chk("both_DRData", bus.DRData, 0);
    bus.DRead  = 1'b0;
    bus.DWrite = 1'b0;
    repeat (3) tick();
    chk("both_ProtErr_sticky", ProtErr, 1);

    // Spurious MAck while idle.
    doReset();
    chk("spur_ProtErr_pre", ProtErr, 0);
    spurAck = 1'b1;
    tick();
    spurAck = 1'b0;
    chk("spur_ProtErr", ProtErr, 1);
    chk("spur_acks", {bus.IAck, bus.DAck}, 0);
    chk("spur_MReq", bus.MReq, 0);
    tick();
    chk("spur_acks_later", {bus.IAck, bus.DAck}, 0);
    chk("spur_ProtErr_sticky", ProtErr, 1);

    // Reset while BUSY_D.
    doReset();
    bus.DRead = 1'b1;
    bus.DAddr = 16'h0500;
    memData   = 32'h44444444;
    memK      = 5;
    tick();
    chk("rst_MReq_busy", bus.MReq, 1);
    tick();
    #2;
    nReset = 1'b0;
    #1;
    chk("rst_MReq_async", bus.MReq, 0);
    bus.DRead = 1'b0;
    bus.DAddr = '0;
    @(posedge Clock);
    @(negedge Clock);
    nReset = 1'b1;
    tick();
    chkAllZero("rst_after");
    begin
      logic anyAck;
      anyAck = 1'b0;
      for (int c = 0; c < 8; c++) begin
        tick();
        anyAck = anyAck | bus.DAck | bus.IAck;
      end
      chk("rst_no_ack", anyAck, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
